// File: rtl/tube_display_ctrl.sv
// Sequencer feeding the 8-digit seven-segment tube driver: optional binary-to-BCD
// conversion, leading-zero blanking, then three register writes (low, high, special).
module tube_display_ctrl #(
   parameter int          BIN_WIDTH = 27,
   parameter logic [31:0] DEC_MAX   = 32'd99999999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_value,
   input  logic        req_mode,
   input  logic        req_blank,
   input  logic [7:0]  req_dp,
   output logic        tube_write_enable,
   output logic [2:0]  tube_address,
   output logic [15:0] tube_write_data,
   output logic        busy,
   output logic        overflow
);

   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, CONV, BLANK, WR_LO, WR_HI, WR_SP} state_t;

   state_t                 state_reg, state_next;
   logic [31:0]            digits_reg, digits_next;
   logic [BIN_WIDTH-1:0]   bin_reg, bin_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   blank_reg, blank_next;
   logic [7:0]             dp_reg, dp_next;
   logic [7:0]             en_reg, en_next;
   logic                   overflow_reg, overflow_next;
   logic                   ready_reg, ready_next;
   logic                   busy_reg, busy_next;
   logic                   we_reg, we_next;
   logic [2:0]             addr_reg, addr_next;
   logic [15:0]            data_reg, data_next;

   logic [31:0]            digits_adj;
   logic [7:0]             nz;
   logic [7:0]             en_lead;

   // Double-dabble correction and per-digit nonzero flags
   for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
      assign digits_adj[gi*4 +: 4] = (digits_reg[gi*4 +: 4] >= 4'd5) ?
                                     digits_reg[gi*4 +: 4] + 4'd3 :
                                     digits_reg[gi*4 +: 4];
      assign nz[gi] = |digits_reg[gi*4 +: 4];
   end

   // en[i] set for every digit at or below the most significant nonzero one
   always_comb begin
      en_lead    = 8'h00;
      en_lead[7] = nz[7];
      for (int i = 6; i >= 0; i--) begin
         en_lead[i] = en_lead[i+1] | nz[i];
      end
      en_lead[0] = 1'b1;
   end

   always_comb begin
      state_next    = state_reg;
      digits_next   = digits_reg;
      bin_next      = bin_reg;
      cnt_next      = cnt_reg;
      blank_next    = blank_reg;
      dp_next       = dp_reg;
      en_next       = en_reg;
      overflow_next = overflow_reg;
      we_next       = 1'b0;
      addr_next     = addr_reg;
      data_next     = data_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               blank_next    = req_blank;
               dp_next       = req_dp;
               overflow_next = 1'b0;
               cnt_next      = '0;
               if (!req_mode) begin
                  digits_next = req_value;
                  state_next  = BLANK;
               end else if (req_value > DEC_MAX) begin
                  digits_next   = 32'h9999_9999;
                  overflow_next = 1'b1;
                  state_next    = BLANK;
               end else begin
                  digits_next = 32'h0;
                  bin_next    = req_value[BIN_WIDTH-1:0];
                  state_next  = CONV;
               end
            end
         end
         CONV: begin
            digits_next = {digits_adj[30:0], bin_reg[BIN_WIDTH-1]};
            bin_next    = {bin_reg[BIN_WIDTH-2:0], 1'b0};
            cnt_next    = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(BIN_WIDTH - 1)) begin
               state_next = BLANK;
            end
         end
         BLANK: begin
            en_next    = blank_reg ? en_lead : 8'hFF;
            state_next = WR_LO;
            we_next    = 1'b1;
            addr_next  = 3'b000;
            data_next  = digits_reg[15:0];
         end
         WR_LO: begin
            state_next = WR_HI;
            we_next    = 1'b1;
            addr_next  = 3'b010;
            data_next  = digits_reg[31:16];
         end
         WR_HI: begin
            state_next = WR_SP;
            we_next    = 1'b1;
            addr_next  = 3'b100;
            data_next  = {en_reg, dp_reg};
         end
         WR_SP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Outputs are registered against the state being entered
      ready_next = (state_next == IDLE);
      busy_next  = (state_next != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         digits_reg   <= '0;
         bin_reg      <= '0;
         cnt_reg      <= '0;
         blank_reg    <= 1'b0;
         dp_reg       <= '0;
         en_reg       <= '0;
         overflow_reg <= 1'b0;
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= 3'b000;
         data_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         digits_reg   <= digits_next;
         bin_reg      <= bin_next;
         cnt_reg      <= cnt_next;
         blank_reg    <= blank_next;
         dp_reg       <= dp_next;
         en_reg       <= en_next;
         overflow_reg <= overflow_next;
         ready_reg    <= ready_next;
         busy_reg     <= busy_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
      end
   end

   assign req_ready         = ready_reg;
   assign busy              = busy_reg;
   assign overflow          = overflow_reg;
   assign tube_write_enable = we_reg;
   assign tube_address      = addr_reg;
   assign tube_write_data   = data_reg;

endmodule

// File: tb/tb_tube_display_ctrl.sv
// Scoreboard bench for tube_display_ctrl: expected writes (with strobe cycle) are
// queued at accept time and checked by an independent strobe monitor.
module tb_tube_display_ctrl;

   localparam int BIN_WIDTH = 27;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_value;
   logic        req_mode;
   logic        req_blank;
   logic [7:0]  req_dp;
   logic        tube_write_enable;
   logic [2:0]  tube_address;
   logic [15:0] tube_write_data;
   logic        busy;
   logic        overflow;

   tube_display_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_value         (req_value),
      .req_mode          (req_mode),
      .req_blank         (req_blank),
      .req_dp            (req_dp),
      .tube_write_enable (tube_write_enable),
      .tube_address      (tube_address),
      .tube_write_data   (tube_write_data),
      .busy              (busy),
      .overflow          (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
      int          cyc;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: display digits, blanking mask and latency from plain arithmetic
   task automatic push_expect(input logic [31:0] v, input logic m, input logic b,
                              input logic [7:0] dp, input int acc);
      logic [31:0] d;
      logic        ovf;
      logic [7:0]  en;
      int          lat;
      int          msd;
      longint      r;
      ovf = 1'b0;
      lat = 0;
      if (!m) begin
         d = v;
      end else if (v > 32'd99999999) begin
         d   = 32'h9999_9999;
         ovf = 1'b1;
      end else begin
         r = v;
         d = 0;
         for (int i = 0; i < 8; i++) begin
            d[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
         end
         lat = BIN_WIDTH;
      end
      msd = 0;
      for (int i = 0; i < 8; i++) if (d[i*4 +: 4] != 0) msd = i;
      en = b ? 8'((1 << (msd + 1)) - 1) : 8'hFF;
      sb.push_back('{3'b000, d[15:0],  acc + 1 + lat, ovf});
      sb.push_back('{3'b010, d[31:16], acc + 2 + lat, ovf});
      sb.push_back('{3'b100, {en, dp}, acc + 3 + lat, ovf});
   endtask

   always @(negedge clock) begin
      if (reset && tube_write_enable) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                     tube_address, tube_write_data, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(tube_address), 32'(e.addr));
            check("wr_data", 32'(tube_write_data), 32'(e.data));
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
            check("overflow", 32'(overflow), 32'(e.ovf));
            $display("write addr=%0b data=0x%04h cycle=%0d overflow=%0b",
                     tube_address, tube_write_data, cyc, overflow);
         end
      end
   end

   // Call at a negedge; returns at the negedge following the accept edge.
   task automatic send(input logic [31:0] v, input logic m, input logic b,
                       input logic [7:0] dp, input bit hold, output int acc);
      int t;
      req_value = v;
      req_mode  = m;
      req_blank = b;
      req_dp    = dp;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 300) begin
         @(negedge clock);
         t++;
      end
      if (!req_ready) begin
         check("ready_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      push_expect(v, m, b, dp, acc);
      $display("accept value=0x%08h mode=%0b blank=%0b dp=0x%02h edge=%0d", v, m, b, dp, acc);
      @(negedge clock);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clock);
         t++;
      end
      check("drain", 32'(sb.size()), 32'd0);
      @(negedge clock);
   endtask

   initial begin
      int a;
      int sel;
      logic [31:0] v;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_value = '0;
      req_mode  = 1'b0;
      req_blank = 1'b0;
      req_dp    = '0;
      repeat (3) @(negedge clock);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_we", 32'(tube_write_enable), 32'd0);
      check("rst_addr", 32'(tube_address), 32'd0);
      check("rst_data", 32'(tube_write_data), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // Directed cases
      send(32'h1234_ABCD, 1'b0, 1'b0, 8'h00, 1'b0, a); drain();
      send(32'd12345,     1'b1, 1'b1, 8'h04, 1'b0, a); drain();
      send(32'd0,         1'b1, 1'b1, 8'h00, 1'b0, a); drain();
      send(32'd99999999,  1'b1, 1'b1, 8'h00, 1'b0, a); drain();
      send(32'd100000000, 1'b1, 1'b1, 8'h00, 1'b0, a); drain();
      check("overflow_sticky", 32'(overflow), 32'd1);

      // Held valid across two requests: second must be accepted at the first IDLE edge
      send(32'h0000_00A5, 1'b0, 1'b1, 8'h81, 1'b1, a);
      req_value = 32'h0BAD_F00D;
      req_blank = 1'b1;
      req_dp    = 8'h3C;
      push_expect(32'h0BAD_F00D, 1'b0, 1'b1, 8'h3C, a + 5);
      while (cyc < a + 5) @(negedge clock);
      req_valid = 1'b0;
      drain();

      // A pulse while busy is dropped
      send(32'h0000_0007, 1'b0, 1'b0, 8'h00, 1'b0, a);
      req_value = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      drain();
      repeat (5) @(negedge clock);

      // Reset asserted during conversion
      send(32'd7654321, 1'b1, 1'b1, 8'h00, 1'b0, a);
      while (cyc < a + 10) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      sb.delete();
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_we", 32'(tube_write_enable), 32'd0);
      check("midrst_data", 32'(tube_write_data), 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      send(32'hCAFE_0123, 1'b0, 1'b1, 8'h10, 1'b0, a); drain();

      // Randomized requests
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       v = $urandom;
            1:       v = $urandom_range(0, 99999999);
            2:       v = $urandom_range(0, 999);
            default: v = 32'd99999990 + $urandom_range(0, 20);
         endcase
         send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, a);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      drain();
      repeat (5) @(negedge clock);
      check("final_idle", 32'(req_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
